// File: rtl/global_int_scheduler.sv
// Timed interrupt sequencer: queues SET/CLEAR/PULSE/TOGGLE commands and fires each one after its delay.
// Also models claim/complete clears, so the interrupt lines into the PLIC change on exact, repeatable cycles.
module global_int_scheduler #(
  parameter int NUM_INT = 127,
  parameter int IDX_W   = 7,
  parameter int DLY_W   = 16,
  parameter int DEPTH   = 8,
  parameter int PULSE_W = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [DLY_W-1:0]   i_cmd_delay,
  input  logic [IDX_W-1:0]   i_cmd_index,
  input  logic [1:0]         i_cmd_op,
  input  logic               i_clr_valid,
  input  logic [IDX_W-1:0]   i_clr_index,
  output logic [NUM_INT-1:0] o_interrupts,
  output logic               o_busy,
  output logic               o_index_err
);

  localparam int               PTR_W         = $clog2(DEPTH);
  localparam logic [IDX_W:0]   LP_NUM_INT    = (IDX_W+1)'(NUM_INT);
  localparam logic [DLY_W-1:0] LP_PULSE_LAST = DLY_W'(PULSE_W-1);
  localparam logic [PTR_W:0]   LP_DEPTH      = (PTR_W+1)'(DEPTH);
  localparam logic [1:0]       OP_SET        = 2'd0;
  localparam logic [1:0]       OP_CLEAR      = 2'd1;
  localparam logic [1:0]       OP_PULSE      = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PULSE} state_t;

  typedef struct packed {
    logic [DLY_W-1:0] delay;
    logic [IDX_W-1:0] index;
    logic [1:0]       op;
  } cmd_t;

  cmd_t               r_fifo [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  state_t             r_state;
  logic [IDX_W-1:0]   r_cur_idx;
  logic [1:0]         r_cur_op;
  logic [DLY_W-1:0]   r_cnt;
  logic [NUM_INT-1:0] r_int;
  logic               r_index_err;

  logic w_push;
  logic w_pop;
  logic w_cur_ok;
  logic w_clr_ok;

  assign o_cmd_ready  = (r_count != LP_DEPTH);
  assign w_push       = i_cmd_valid && o_cmd_ready;
  assign w_pop        = (r_state == ST_IDLE) && (r_count != '0);
  assign w_cur_ok     = {1'b0, r_cur_idx} < LP_NUM_INT;
  assign w_clr_ok     = {1'b0, i_clr_index} < LP_NUM_INT;
  assign o_interrupts = r_int;
  assign o_index_err  = r_index_err;
  assign o_busy       = (r_count != '0) || (r_state != ST_IDLE);

  // ready only looks at the registered count, so a pop on a full FIFO frees the slot a cycle later
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= '{delay: i_cmd_delay, index: i_cmd_index, op: i_cmd_op};
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The clear is written first so a same-line FSM write later in this block takes precedence.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_cur_idx   <= '0;
      r_cur_op    <= '0;
      r_cnt       <= '0;
      r_int       <= '0;
      r_index_err <= 1'b0;
    end else begin
      if (i_clr_valid) begin
        if (w_clr_ok) r_int[i_clr_index] <= 1'b0;
        else          r_index_err        <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cur_idx <= r_fifo[r_rd_ptr].index;
            r_cur_op  <= r_fifo[r_rd_ptr].op;
            r_cnt     <= r_fifo[r_rd_ptr].delay;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DLY_W'(1);
          end else begin
            if (!w_cur_ok) begin
              r_index_err <= 1'b1;
            end else begin
              case (r_cur_op)
                OP_SET:   r_int[r_cur_idx] <= 1'b1;
                OP_CLEAR: r_int[r_cur_idx] <= 1'b0;
                OP_PULSE: r_int[r_cur_idx] <= 1'b1;
                default:  r_int[r_cur_idx] <= ~r_int[r_cur_idx];
              endcase
            end
            if (r_cur_op == OP_PULSE) begin
              r_cnt   <= LP_PULSE_LAST;
              r_state <= ST_PULSE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_PULSE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - DLY_W'(1);
          end else begin
            if (w_cur_ok) r_int[r_cur_idx] <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
